// File: rtl/mdu_iter.sv
// mdu_iter -- iterative multiply / divide unit for the EX stage.
//
// Takes the multiply, divide and remainder ops off the single-cycle ALU
// path. It computes one result bit per cycle behind a valid/ready
// handshake. EX stalls while busy is high.
//
// Ports
//   clk        core clock, all state changes on the rising edge
//   rst        synchronous active-high reset (has priority over flush)
//   flush      pipeline kill; abandons any in-flight op, result discarded
//   in_valid   EX presents an op
//   in_ready   unit can accept (IDLE only)
//   op         ALU op code; ALU_MUL / ALU_DIV / ALU_REM are executed,
//              any other code completes with result 0
//   a, b       unsigned operands (multiplicand/dividend, multiplier/divisor)
//   busy       high in every state except IDLE
//   out_valid  result available, held with result until out_ready
//   out_ready  consumer takes the result
//   result     product low half, quotient or remainder
//
// Configuration macro: MDU_EARLY_OUT_EN
//   When defined, multiply by zero and divide by zero skip the iterations
//   and finish with the short two-cycle latency. Results are bit-identical
//   either way; only the latency changes.
module mdu_iter #(
    parameter int          XLEN    = 64,
    parameter int          CNT_W   = 7,
    parameter logic [3:0]  ALU_MUL = 4'd10,
    parameter logic [3:0]  ALU_DIV = 4'd11,
    parameter logic [3:0]  ALU_REM = 4'd12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    // SHORT is a one-cycle pass state so that ops which need no iteration
    // still leave through the same registered result path (latency 2).
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        DIV   = 3'd2,
        SHORT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        op_r;
    logic [XLEN-1:0]   a_r;        // multiplicand, or dividend/quotient shifter
    logic [XLEN-1:0]   b_r;        // multiplier shifter, or fixed divisor
    logic [XLEN-1:0]   acc_r;      // product accumulator, or partial remainder
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   result_r;
    logic              in_ready_r;
    logic              busy_r;
    logic              out_valid_r;

    logic              accept_s;
    logic              last_s;
    logic              early_s;
    logic [XLEN-1:0]   early_val_s;
    logic [XLEN:0]     div_r_s;
    logic [XLEN:0]     div_diff_s;
    logic              div_ge_s;
    logic [XLEN-1:0]   acc_n_s;
    logic [XLEN-1:0]   a_n_s;
    logic [XLEN-1:0]   b_n_s;
    logic [XLEN-1:0]   res_s;

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;

    assign accept_s = in_valid & in_ready_r & ~flush;
    assign last_s   = (cnt_r == CNT_W'(XLEN - 1));

    // Zero-operand shortcut decode at accept time.
    always_comb begin
        early_s     = 1'b0;
        early_val_s = {XLEN{1'b0}};
`ifdef MDU_EARLY_OUT_EN
        if ((op == ALU_MUL) && ((a == {XLEN{1'b0}}) || (b == {XLEN{1'b0}}))) begin
            early_s     = 1'b1;
            early_val_s = {XLEN{1'b0}};
        end else if ((op == ALU_DIV) && (b == {XLEN{1'b0}})) begin
            early_s     = 1'b1;
            early_val_s = {XLEN{1'b1}};
        end else if ((op == ALU_REM) && (b == {XLEN{1'b0}})) begin
            early_s     = 1'b1;
            early_val_s = a;
        end else begin
            early_s     = 1'b0;
            early_val_s = {XLEN{1'b0}};
        end
`endif
    end

    // One iteration of shift-add multiply or restoring divide.
    // The full partial remainder is kept in the trial value, so the
    // XLEN+1-bit subtract never loses a carry; its top bit is the borrow.
    always_comb begin
        div_r_s    = {acc_r, a_r[XLEN-1]};
        div_diff_s = div_r_s - {1'b0, b_r};
        div_ge_s   = ~div_diff_s[XLEN];
        acc_n_s    = acc_r;
        a_n_s      = a_r;
        b_n_s      = b_r;
        res_s      = acc_r;
        case (state_r)
            MUL: begin
                acc_n_s = acc_r + (b_r[0] ? a_r : {XLEN{1'b0}});
                a_n_s   = {a_r[XLEN-2:0], 1'b0};
                b_n_s   = {1'b0, b_r[XLEN-1:1]};
                res_s   = acc_n_s;
            end
            DIV: begin
                acc_n_s = div_ge_s ? div_diff_s[XLEN-1:0] : div_r_s[XLEN-1:0];
                a_n_s   = {a_r[XLEN-2:0], div_ge_s};
                res_s   = (op_r == ALU_DIV) ? a_n_s : acc_n_s;
            end
            default: begin
                res_s = acc_r;
            end
        endcase
    end

    // Next-state logic; flush returns every state to IDLE.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (early_s)             state_s = SHORT;
                        else if (op == ALU_MUL)  state_s = MUL;
                        else if ((op == ALU_DIV) || (op == ALU_REM)) state_s = DIV;
                        else                     state_s = SHORT;
                    end else begin
                        state_s = IDLE;
                    end
                end
                MUL, DIV: begin
                    if (last_s) state_s = DONE;
                    else        state_s = state_r;
                end
                SHORT:   state_s = DONE;
                DONE: begin
                    if (out_ready) state_s = IDLE;
                    else           state_s = DONE;
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // State, handshake outputs, result and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            op_r        <= 4'd0;
            a_r         <= {XLEN{1'b0}};
            b_r         <= {XLEN{1'b0}};
            acc_r       <= {XLEN{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            busy_r      <= (state_s != IDLE);
            out_valid_r <= (state_s == DONE);

            if (flush) begin
                result_r <= {XLEN{1'b0}};
            end else if ((state_s == DONE) && (state_r != DONE)) begin
                result_r <= res_s;
            end else begin
                result_r <= result_r;
            end

            if (accept_s) begin
                op_r  <= op;
                a_r   <= a;
                b_r   <= b;
                acc_r <= early_val_s;   // zero unless a shortcut preloads the answer
                cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == MUL) || (state_r == DIV)) begin
                a_r   <= a_n_s;
                b_r   <= b_n_s;
                acc_r <= acc_n_s;
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                a_r   <= a_r;
                b_r   <= b_r;
                acc_r <= acc_r;
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed testbench for mdu_iter with hand-computed expected values.
module tb_mdu_iter;

    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;
    localparam logic [3:0] OP_REM = 4'd12;
    localparam logic [3:0] OP_XOR = 4'd4;
`ifdef MDU_EARLY_OUT_EN
    localparam int DIV0_LAT = 2;
`else
    localparam int DIV0_LAT = 65;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;
    int lat;
    int busy_cnt;
    int bad;

    mdu_iter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an op for one accepted cycle; returns at T+1 (+1 time unit).
    task automatic launch(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        check("in_ready_pre", {63'd0, in_ready}, 64'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 4'd0; a = 64'hDEAD_BEEF_0000_5555; b = 64'h1;
    endtask

    // Wait for out_valid; lat is the cycle offset from accept cycle T.
    task automatic wait_result(output int l, output int bc);
        l  = 1;
        bc = 0;
        while (!out_valid && l < 200) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    // Hold out_ready low for some cycles, then consume.
    task automatic consume(input int hold, input logic [63:0] exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_result", result, exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; a = 64'd0; b = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", result, 64'd0);

        // 1: 7*6, latency and busy window
        launch(OP_MUL, 64'd7, 64'd6);
        wait_result(lat, busy_cnt);
        check("mul_lat", lat, 64'd65);
        check("mul_busy_cycles", busy_cnt, 64'd64);
        check("mul_busy_done", {63'd0, busy}, 64'd1);
        check("mul_result", result, 64'd42);
        consume(0, 64'd42);

        // 2: wrap-around multiply
        launch(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_result(lat, busy_cnt);
        check("mulw_result", result, 64'd1);
        consume(0, 64'd1);

        // 3: divide and remainder with output hold
        launch(OP_DIV, 64'd100, 64'd7);
        wait_result(lat, busy_cnt);
        check("div_lat", lat, 64'd65);
        check("div_result", result, 64'd14);
        consume(5, 64'd14);
        launch(OP_REM, 64'd100, 64'd7);
        wait_result(lat, busy_cnt);
        check("rem_result", result, 64'd2);
        consume(5, 64'd2);

        // 4: divide by zero
        launch(OP_DIV, 64'h1234, 64'd0);
        wait_result(lat, busy_cnt);
        check("div0_lat", lat, DIV0_LAT);
        check("div0_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        consume(0, 64'hFFFF_FFFF_FFFF_FFFF);
        launch(OP_REM, 64'h1234, 64'd0);
        wait_result(lat, busy_cnt);
        check("rem0_lat", lat, DIV0_LAT);
        check("rem0_result", result, 64'h1234);
        consume(0, 64'h1234);

        // Flush with in_valid in IDLE: flush wins
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = OP_MUL; a = 64'd3; b = 64'd3;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle_busy", {63'd0, busy}, 64'd0);
        check("flush_idle_ready", {63'd0, in_ready}, 64'd1);

        // 5: flush at T+30 of a divide
        launch(OP_DIV, 64'd100, 64'd7);
        repeat (29) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        bad = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (out_valid) bad++;
        end
        check("flush_no_valid", bad, 64'd0);
        launch(OP_DIV, 64'd9, 64'd3);
        wait_result(lat, busy_cnt);
        check("div93_result", result, 64'd3);
        consume(0, 64'd3);

        // Unsupported op: result 0 at T+2
        launch(OP_XOR, 64'd3, 64'd5);
        wait_result(lat, busy_cnt);
        check("xor_lat", lat, 64'd2);
        check("xor_result", result, 64'd0);
        consume(0, 64'd0);

        // 6: rst at T+10 of a multiply (previous result nonzero first)
        launch(OP_MUL, 64'd5, 64'd5);
        wait_result(lat, busy_cnt);
        consume(0, 64'd25);
        launch(OP_MUL, 64'd5, 64'd5);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("mrst_busy", {63'd0, busy}, 64'd0);
        check("mrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mrst_result", result, 64'd0);

        // Unit must be usable after the mid-op reset
        launch(OP_MUL, 64'd12, 64'd11);
        wait_result(lat, busy_cnt);
        check("after_rst_result", result, 64'd132);
        consume(0, 64'd132);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
